// File: rtl/vga_cell_write_arbiter.sv
// Arbitrates the single-port cell framebuffer between video scan-out reads, buffered CPU
// cell writes and a fill-colour clear engine (video > clear > CPU drain).
module vga_cell_write_arbiter #(
   parameter int unsigned CELLS      = 192,
   parameter int unsigned ADDR_W     = 8,
   parameter int unsigned COLOR_W    = 3,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               iVidRdReq,
   input  logic [ADDR_W-1:0]  iVidAddr,
   output logic [COLOR_W-1:0] oVidData,
   output logic               oVidValid,
   input  logic               iCpuWrEn,
   input  logic [15:0]        iCpuAddr,
   input  logic [COLOR_W-1:0] iCpuColor,
   output logic               oCpuStall,
   output logic               oCpuAddrErr,
   input  logic               iClearStart,
   input  logic [COLOR_W-1:0] iClearColor,
   output logic               oClearBusy,
   output logic               oFbWe,
   output logic [ADDR_W-1:0]  oFbAddr,
   output logic [COLOR_W-1:0] oFbWData,
   input  logic [COLOR_W-1:0] iFbRdData
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned ENT_W = ADDR_W + COLOR_W;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DRAIN = 2'd1,
      S_CLEAR = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   logic [ENT_W-1:0]   r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]   r_wr_ptr;
   logic [PTR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic [CNT_W-1:0]   r_drain_left;
   logic [CNT_W-1:0]   w_drain_nxt;
   logic [CNT_W-1:0]   w_post_pop_cnt;
   logic [ADDR_W-1:0]  r_clr_cnt;
   logic [ADDR_W-1:0]  w_clr_cnt_nxt;
   logic [COLOR_W-1:0] r_clr_color;
   logic [COLOR_W-1:0] w_clr_color_nxt;
   logic               r_busy;
   logic               r_vid_valid;
   logic               r_addr_err;

   logic               w_full;
   logic               w_empty;
   logic               w_accept;
   logic               w_in_range;
   logic               w_push;
   logic               w_pop;
   logic               w_clr_wr;
   logic [ENT_W-1:0]   w_head;

   // Stall depends only on the registered count, so a same-cycle pop never frees a slot.
   assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_empty    = (r_count == '0);
   assign w_accept   = iCpuWrEn & ~w_full;
   assign w_in_range = (iCpuAddr < 16'(CELLS));
   assign w_push     = w_accept & w_in_range;
   assign w_head     = r_mem[r_rd_ptr];
   assign w_post_pop_cnt = r_count - CNT_W'(w_pop);

   assign oCpuStall   = w_full;
   assign oVidValid   = r_vid_valid;
   assign oVidData    = r_vid_valid ? iFbRdData : '0;
   assign oCpuAddrErr = r_addr_err;
   assign oClearBusy  = r_busy;

   // RAM port ownership, fixed priority: video read, clear write, CPU FIFO pop.
   always_comb begin
      oFbWe    = 1'b0;
      oFbAddr  = '0;
      oFbWData = '0;
      w_pop    = 1'b0;
      w_clr_wr = 1'b0;
      if (iVidRdReq) begin
         oFbAddr = iVidAddr;
      end else if (r_state == S_CLEAR) begin
         w_clr_wr = 1'b1;
         oFbWe    = 1'b1;
         oFbAddr  = r_clr_cnt;
         oFbWData = r_clr_color;
      end else if (!w_empty) begin
         w_pop    = 1'b1;
         oFbWe    = 1'b1;
         oFbAddr  = w_head[ENT_W-1:COLOR_W];
         oFbWData = w_head[COLOR_W-1:0];
      end
   end

   // Clear sequencing: drain only the writes queued before the start, then fill.
   always_comb begin
      w_state_nxt     = r_state;
      w_drain_nxt     = r_drain_left;
      w_clr_cnt_nxt   = r_clr_cnt;
      w_clr_color_nxt = r_clr_color;
      case (r_state)
         S_IDLE: begin
            if (iClearStart) begin
               w_clr_color_nxt = iClearColor;
               w_drain_nxt     = w_post_pop_cnt;
               w_state_nxt     = (w_post_pop_cnt == '0) ? S_CLEAR : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_pop) begin
               w_drain_nxt = r_drain_left - CNT_W'(1);
               if (r_drain_left == CNT_W'(1)) begin
                  w_state_nxt = S_CLEAR;
               end
            end
         end
         S_CLEAR: begin
            if (w_clr_wr) begin
               if (r_clr_cnt == ADDR_W'(CELLS - 1)) begin
                  w_clr_cnt_nxt = '0;
                  w_state_nxt   = S_IDLE;
               end else begin
                  w_clr_cnt_nxt = r_clr_cnt + ADDR_W'(1);
               end
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_state      <= S_IDLE;
         r_drain_left <= '0;
         r_clr_cnt    <= '0;
         r_clr_color  <= '0;
         r_busy       <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_drain_left <= w_drain_nxt;
         r_clr_cnt    <= w_clr_cnt_nxt;
         r_clr_color  <= w_clr_color_nxt;
         r_busy       <= (w_state_nxt != S_IDLE);
      end
   end

   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_vid_valid <= 1'b0;
         r_addr_err  <= 1'b0;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
      end else begin
         r_vid_valid <= iVidRdReq;
         r_addr_err  <= w_accept & ~w_in_range;
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   // Payload storage needs no reset; the pointers define what is valid.
   always_ff @(posedge Clock) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {iCpuAddr[ADDR_W-1:0], iCpuColor};
      end
   end

endmodule

// File: tb/tb_vga_cell_write_arbiter.sv
// Scoreboard bench for vga_cell_write_arbiter: expected RAM writes are queued as stimulus is
// driven and compared in order against every oFbWe cycle; a behavioural RAM answers reads.
module tb_vga_cell_write_arbiter;

   localparam int unsigned CELLS   = 192;
   localparam int unsigned ADDR_W  = 8;
   localparam int unsigned COLOR_W = 3;

   logic               Clock = 1'b0;
   logic               Reset = 1'b0;
   logic               iVidRdReq = 1'b0;
   logic [ADDR_W-1:0]  iVidAddr = '0;
   logic [COLOR_W-1:0] oVidData;
   logic               oVidValid;
   logic               iCpuWrEn = 1'b0;
   logic [15:0]        iCpuAddr = '0;
   logic [COLOR_W-1:0] iCpuColor = '0;
   logic               oCpuStall;
   logic               oCpuAddrErr;
   logic               iClearStart = 1'b0;
   logic [COLOR_W-1:0] iClearColor = '0;
   logic               oClearBusy;
   logic               oFbWe;
   logic [ADDR_W-1:0]  oFbAddr;
   logic [COLOR_W-1:0] oFbWData;
   logic [COLOR_W-1:0] iFbRdData;

   int checks   = 0;
   int failures = 0;
   logic [ADDR_W+COLOR_W-1:0] exp_q [$];
   logic [ADDR_W+COLOR_W-1:0] sb_e;
   logic [COLOR_W-1:0] fb_mem [256];
   logic [COLOR_W-1:0] fb_rd = '0;

   vga_cell_write_arbiter dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .iVidRdReq   (iVidRdReq),
      .iVidAddr    (iVidAddr),
      .oVidData    (oVidData),
      .oVidValid   (oVidValid),
      .iCpuWrEn    (iCpuWrEn),
      .iCpuAddr    (iCpuAddr),
      .iCpuColor   (iCpuColor),
      .oCpuStall   (oCpuStall),
      .oCpuAddrErr (oCpuAddrErr),
      .iClearStart (iClearStart),
      .iClearColor (iClearColor),
      .oClearBusy  (oClearBusy),
      .oFbWe       (oFbWe),
      .oFbAddr     (oFbAddr),
      .oFbWData    (oFbWData),
      .iFbRdData   (iFbRdData)
   );

   always #5 Clock = ~Clock;

   initial begin
      foreach (fb_mem[i]) fb_mem[i] = '0;
   end

   // Synchronous single-port RAM model.
   always @(posedge Clock) begin
      if (oFbWe) fb_mem[oFbAddr] <= oFbWData;
      fb_rd <= fb_mem[oFbAddr];
   end
   assign iFbRdData = fb_rd;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic exp_wr(input int unsigned addr, input int unsigned color);
      exp_q.push_back({ADDR_W'(addr), COLOR_W'(color)});
   endtask

   // Every RAM write must match the next expected write, in order.
   always @(negedge Clock) begin
      if (Reset && oFbWe) begin
         if (exp_q.size() == 0) begin
            check("sb_unexpected_we", 32'(oFbWe), 32'd0);
         end else begin
            sb_e = exp_q.pop_front();
            check("sb_addr", 32'(oFbAddr), 32'(sb_e[ADDR_W+COLOR_W-1:COLOR_W]));
            check("sb_data", 32'(oFbWData), 32'(sb_e[COLOR_W-1:0]));
         end
      end
   end

   initial begin
      int busy_cnt;
      int we_cnt;
      int bad;
      logic found;

      // Reset values
      #12;
      check("rst_vid_valid", 32'(oVidValid), 32'd0);
      check("rst_vid_data", 32'(oVidData), 32'd0);
      check("rst_addr_err", 32'(oCpuAddrErr), 32'd0);
      check("rst_busy", 32'(oClearBusy), 32'd0);
      check("rst_stall", 32'(oCpuStall), 32'd0);
      check("rst_we", 32'(oFbWe), 32'd0);
      tick();
      Reset = 1'b1;
      tick();

      // Single CPU write lands one cycle after the strobe
      iCpuWrEn = 1'b1; iCpuAddr = 16'd20; iCpuColor = 3'b100; exp_wr(20, 4);
      @(negedge Clock);
      check("t1_we_strobe_cycle", 32'(oFbWe), 32'd0);
      tick();
      iCpuWrEn = 1'b0;
      @(negedge Clock);
      check("t1_we", 32'(oFbWe), 32'd1);
      check("t1_addr", 32'(oFbAddr), 32'd20);
      check("t1_data", 32'(oFbWData), 32'd4);
      tick();
      tick();

      // Video burst of 10 cycles with 6 back-to-back CPU writes
      iVidRdReq = 1'b1; iVidAddr = 8'd20;
      for (int k = 0; k < 10; k++) begin
         iCpuWrEn = (k < 6); iCpuAddr = 16'(30 + k); iCpuColor = 3'(k + 1);
         if (k < 4) exp_wr(30 + k, k + 1);
         @(negedge Clock);
         check("t2_stall", 32'(oCpuStall), 32'(k >= 4));
         check("t2_no_we", 32'(oFbWe), 32'd0);
         check("t2_vid_addr", 32'(oFbAddr), 32'd20);
         check("t2_vid_valid", 32'(oVidValid), 32'(k >= 1));
         check("t2_vid_data", 32'(oVidData), (k >= 1) ? 32'd4 : 32'd0);
         tick();
      end
      iVidRdReq = 1'b0; iCpuWrEn = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge Clock);
         check("t2_drain_we", 32'(oFbWe), 32'd1);
         check("t2_drain_addr", 32'(oFbAddr), 32'(30 + k));
         tick();
      end
      @(negedge Clock);
      check("t2_after_drain_we", 32'(oFbWe), 32'd0);
      check("t2_stall_clear", 32'(oCpuStall), 32'd0);
      tick();

      // Out-of-range address, then the last valid cell
      iCpuWrEn = 1'b1; iCpuAddr = 16'd192; iCpuColor = 3'd5;
      tick();
      iCpuWrEn = 1'b0;
      @(negedge Clock);
      check("t3_err_pulse", 32'(oCpuAddrErr), 32'd1);
      check("t3_err_no_we", 32'(oFbWe), 32'd0);
      tick();
      @(negedge Clock);
      check("t3_err_one_cycle", 32'(oCpuAddrErr), 32'd0);
      check("t3_err_still_no_we", 32'(oFbWe), 32'd0);
      tick();
      iCpuWrEn = 1'b1; iCpuAddr = 16'd191; iCpuColor = 3'd2; exp_wr(191, 2);
      tick();
      iCpuWrEn = 1'b0;
      @(negedge Clock);
      check("t3_last_we", 32'(oFbWe), 32'd1);
      check("t3_last_addr", 32'(oFbAddr), 32'd191);
      check("t3_last_err", 32'(oCpuAddrErr), 32'd0);
      tick();

      // Full clear with idle video
      iClearStart = 1'b1; iClearColor = 3'b000;
      for (int i = 0; i < CELLS; i++) exp_wr(i, 0);
      @(negedge Clock);
      check("t4_busy_start", 32'(oClearBusy), 32'd0);
      tick();
      iClearStart = 1'b0;
      busy_cnt = 1; we_cnt = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge Clock);
         if (!oClearBusy) break;
         busy_cnt++;
         if (oFbWe) we_cnt++;
      end
      check("t4_busy_cycles", 32'(busy_cnt), 32'd193);
      check("t4_we_cycles", 32'(we_cnt), 32'd192);
      check("t4_we_after", 32'(oFbWe), 32'd0);
      tick();

      // Clear with two queued CPU writes and one CPU write during the fill
      iVidRdReq = 1'b1; iVidAddr = 8'd0;
      iCpuWrEn = 1'b1; iCpuAddr = 16'd5; iCpuColor = 3'd3; exp_wr(5, 3);
      tick();
      iCpuAddr = 16'd7; iCpuColor = 3'd6; exp_wr(7, 6);
      tick();
      iCpuWrEn = 1'b0; iClearStart = 1'b1; iClearColor = 3'd0;
      for (int i = 0; i < CELLS; i++) exp_wr(i, 0);
      tick();
      iClearStart = 1'b0; iVidRdReq = 1'b0;
      @(negedge Clock);
      check("t5_busy_drain", 32'(oClearBusy), 32'd1);
      check("t5_drain_addr0", 32'(oFbAddr), 32'd5);
      tick();
      @(negedge Clock);
      check("t5_drain_addr1", 32'(oFbAddr), 32'd7);
      tick();
      @(negedge Clock);
      check("t5_clear_first_we", 32'(oFbWe), 32'd1);
      check("t5_clear_first_addr", 32'(oFbAddr), 32'd0);
      tick();
      tick();
      iCpuWrEn = 1'b1; iCpuAddr = 16'd5; iCpuColor = 3'd7; exp_wr(5, 7);
      iVidRdReq = 1'b1; iVidAddr = 8'd5;
      @(negedge Clock);
      check("t5_vid_pauses_clear", 32'(oFbWe), 32'd0);
      tick();
      iCpuWrEn = 1'b0; iVidRdReq = 1'b0;
      for (int i = 0; i < 400; i++) begin
         @(negedge Clock);
         if (!oClearBusy) break;
      end
      check("t5_busy_done", 32'(oClearBusy), 32'd0);
      repeat (4) tick();
      check("t5_ram_cell5", 32'(fb_mem[5]), 32'd7);
      bad = 0;
      for (int i = 0; i < CELLS; i++) if (i != 5 && fb_mem[i] != '0) bad++;
      check("t5_ram_others_zero", 32'(bad), 32'd0);

      // Reset mid-clear discards the FIFO; a fresh clear restarts at address 0
      iClearStart = 1'b1; iClearColor = 3'd5;
      for (int i = 0; i < CELLS; i++) exp_wr(i, 5);
      tick();
      iClearStart = 1'b0;
      tick();
      iCpuWrEn = 1'b1; iCpuAddr = 16'd9; iCpuColor = 3'd1; exp_wr(9, 1);
      tick();
      iCpuWrEn = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge Clock);
         if (oFbWe && oFbAddr == 8'd100) begin
            found = 1'b1;
            break;
         end
      end
      check("t6_reach_100", 32'(found), 32'd1);
      #1;
      Reset = 1'b0;
      #1;
      check("t6_rst_busy", 32'(oClearBusy), 32'd0);
      check("t6_rst_we", 32'(oFbWe), 32'd0);
      check("t6_rst_addr", 32'(oFbAddr), 32'd0);
      check("t6_rst_stall", 32'(oCpuStall), 32'd0);
      check("t6_rst_vid_valid", 32'(oVidValid), 32'd0);
      check("t6_rst_err", 32'(oCpuAddrErr), 32'd0);
      exp_q.delete();
      tick();
      Reset = 1'b1;
      tick();
      @(negedge Clock);
      check("t6_fifo_discarded", 32'(oFbWe), 32'd0);
      tick();
      iClearStart = 1'b1; iClearColor = 3'd1;
      for (int i = 0; i < CELLS; i++) exp_wr(i, 1);
      tick();
      iClearStart = 1'b0;
      @(negedge Clock);
      check("t6_restart_we", 32'(oFbWe), 32'd1);
      check("t6_restart_addr", 32'(oFbAddr), 32'd0);
      for (int i = 0; i < 400; i++) begin
         @(negedge Clock);
         if (!oClearBusy) break;
      end
      check("t6_busy_done", 32'(oClearBusy), 32'd0);
      repeat (3) tick();
      check("sb_all_consumed", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
